// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default operand width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the sum is formed by two cascaded XOR cells.
module XOR_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  XOR_gate u_xor_ab (.a(a), .b(b),  .y(p));
  XOR_gate u_xor_pc (.a(p), .b(ci), .y(s));

  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full-adder evaluation per clock, result registered after WIDTH shifts.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-2:0] s_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_sr_d;

  full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Only the upper WIDTH-1 partial-sum bits are kept; bit 0 would be shifted out on the last edge anyway.
  assign s_sr_d = {fa_s, s_sr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          s_sr_q  <= s_sr_d[WIDTH-1:1];
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            sum_q   <= s_sr_d;
            cout_q  <= fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=5 against an arithmetic reference.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start5, cin5, busy5, done5, cout5;
  logic [4:0] a5, b5, sum5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .cin(cin5),
    .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
  );

  // Pulse start for one cycle; returns at the negedge after the capturing edge.
  task automatic pulse8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input int limit, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (done8) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start5 = 1'b1; a5 = 5'h1F; b5 = 5'h1F; cin5 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b cout=%b sum=%h required all zero", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy5, done5, cout5, sum5} !== 8'd0) begin
      errors++;
      $display("FAIL reset5 busy=%b done=%b cout=%b sum=%h required all zero", busy5, done5, cout5, sum5);
    end
    rst = 1'b0; start8 = 1'b0; start5 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int  busy_cnt;
    int  n;
    pulse8(8'h35, 8'h4A, 1'b0);
    busy_cnt = busy8 ? 1 : 0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
      if (busy8) busy_cnt++;
    end
    checks++;
    if (!done8) begin
      errors++;
      $display("FAIL basic_done_timeout waited=%0d required done within 20", n);
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles got=%0d required=8", busy_cnt);
    end
    checks++;
    if ({cout8, sum8} !== 9'h07F || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result cout=%b sum=%h busy=%b required cout=0 sum=7f busy=0", cout8, sum8, busy8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width done=%b required 0 one cycle later", done8);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({cout8, sum8} !== 9'h07F) begin
      errors++;
      $display("FAIL basic_hold cout=%b sum=%h required 0/7f", cout8, sum8);
    end
  endtask

  task automatic test_full_ripple();
    int n; bit seen;
    pulse8(8'hFF, 8'h01, 1'b0);
    wait_done8(20, n, seen);
    checks++;
    if (!seen || {cout8, sum8} !== 9'h100) begin
      errors++;
      $display("FAIL ripple_ff_01 seen=%b cout=%b sum=%h required 1/00", seen, cout8, sum8);
    end
    @(negedge clk);
    pulse8(8'hFF, 8'hFF, 1'b1);
    wait_done8(20, n, seen);
    checks++;
    if (!seen || {cout8, sum8} !== 9'h1FF) begin
      errors++;
      $display("FAIL ripple_ff_ff_1 seen=%b cout=%b sum=%h required 1/ff", seen, cout8, sum8);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int n; bit seen; int extra;
    pulse8(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(20, n, seen);
    checks++;
    if (!seen || {cout8, sum8} !== 9'h030) begin
      errors++;
      $display("FAIL busy_restart seen=%b cout=%b sum=%h required 0/30", seen, cout8, sum8);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_dropped extra_active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int extra;
    pulse8(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL midreset busy=%b sum=%h cout=%b required 0/00/0", busy8, sum8, cout8);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL midreset_no_done done_pulses=%0d required 0", extra);
    end
  endtask

  task automatic test_random8();
    int last; int n; logic [8:0] exp;
    last = -1;
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
    for (int op = 0; op < 500; op++) begin
      exp = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done8 && n < 30);
      checks++;
      if (!done8) begin
        errors++;
        $display("FAIL rand8_timeout op=%0d waited=%0d", op, n);
        break;
      end
      checks++;
      if ({cout8, sum8} !== exp) begin
        errors++;
        $display("FAIL rand8_sum op=%0d got=%h required=%h", op, {cout8, sum8}, exp);
      end
      if (last >= 0) begin
        checks++;
        if (cyc - last != 10) begin
          errors++;
          $display("FAIL rand8_spacing op=%0d got=%0d required=10", op, cyc - last);
        end
      end
      last = cyc;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    start8 = 1'b0;
  endtask

  task automatic test_random5();
    int last; int n; logic [5:0] exp;
    last = -1;
    @(negedge clk);
    a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom); start5 = 1'b1;
    for (int op = 0; op < 500; op++) begin
      exp = {1'b0, a5} + {1'b0, b5} + {5'd0, cin5};
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done5 && n < 30);
      checks++;
      if (!done5) begin
        errors++;
        $display("FAIL rand5_timeout op=%0d waited=%0d", op, n);
        break;
      end
      checks++;
      if ({cout5, sum5} !== exp) begin
        errors++;
        $display("FAIL rand5_sum op=%0d got=%h required=%h", op, {cout5, sum5}, exp);
      end
      if (last >= 0) begin
        checks++;
        if (cyc - last != 7) begin
          errors++;
          $display("FAIL rand5_spacing op=%0d got=%0d required=7", op, cyc - last);
        end
      end
      last = cyc;
      a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
    end
    start5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_ripple();
    test_start_while_busy();
    test_reset_mid_op();
    fork
      test_random8();
      test_random5();
    join
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
